// File: rtl/csr_file.sv
// CSR file beside writeback: masked CSR writes, exception/ertn state,
// interrupt pending flag and the TCFG/TVAL countdown timer.
module csr_file #(
  parameter int SAVE_NUM = 4,
  parameter int TIMER_W  = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        csr_re,
  input  logic [13:0] csr_num,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic        ertn_flush,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  input  logic [31:0] coreid_in,
  output logic        has_int,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_pc
);

  localparam logic [13:0] A_CRMD   = 14'h0;
  localparam logic [13:0] A_PRMD   = 14'h1;
  localparam logic [13:0] A_ECFG   = 14'h4;
  localparam logic [13:0] A_ESTAT  = 14'h5;
  localparam logic [13:0] A_ERA    = 14'h6;
  localparam logic [13:0] A_BADV   = 14'h7;
  localparam logic [13:0] A_EENTRY = 14'hC;
  localparam logic [13:0] A_TID    = 14'h40;
  localparam logic [13:0] A_TCFG   = 14'h41;
  localparam logic [13:0] A_TVAL   = 14'h42;
  localparam logic [13:0] A_TICLR  = 14'h44;
  localparam logic [12:0] LIE_MASK = 13'h1BFF;
  localparam logic [5:0]  EC_ADEF  = 6'h08;
  localparam logic [5:0]  EC_ALE   = 6'h09;

  logic [3:0]         crmd_q, crmd_d;
  logic [2:0]         prmd_q, prmd_d;
  logic [12:0]        lie_q, lie_d;
  logic [12:0]        is_q, is_d;
  logic [5:0]         ecode_q, ecode_d;
  logic [8:0]         esub_q, esub_d;
  logic [31:0]        era_q, era_d;
  logic [31:0]        badv_q, badv_d;
  logic [31:6]        eentry_q, eentry_d;
  logic [31:0]        save_q [SAVE_NUM];
  logic [31:0]        save_d [SAVE_NUM];
  logic [31:0]        tid_q, tid_d;
  logic [TIMER_W-1:0] tcfg_q, tcfg_d;
  logic [TIMER_W-1:0] tval_q, tval_d;

  logic        wr;
  logic [31:0] keep;
  logic [31:0] wsel;
  logic        tcfg_wr;
  logic        ticlr;
  logic        timer_fire;
  logic        unused_re;

  assign unused_re = csr_re;

  function automatic logic [13:0] save_addr(input int i);
    return 14'(48 + i);
  endfunction

  assign wr   = csr_we & ~wb_ex;
  assign keep = ~csr_wmask;
  assign wsel = csr_wvalue & csr_wmask;

  assign tcfg_wr = wr && (csr_num == A_TCFG);
  assign ticlr   = wr && (csr_num == A_TICLR) && wsel[0];

  always_comb begin
    csr_rvalue = '0;
    case (csr_num)
      A_CRMD:   csr_rvalue = {28'd0, crmd_q};
      A_PRMD:   csr_rvalue = {29'd0, prmd_q};
      A_ECFG:   csr_rvalue = {19'd0, lie_q};
      A_ESTAT:  csr_rvalue = {1'b0, esub_q, ecode_q, 3'd0, is_q};
      A_ERA:    csr_rvalue = era_q;
      A_BADV:   csr_rvalue = badv_q;
      A_EENTRY: csr_rvalue = {eentry_q, 6'd0};
      A_TID:    csr_rvalue = tid_q;
      A_TCFG:   csr_rvalue = 32'(tcfg_q);
      A_TVAL:   csr_rvalue = 32'(tval_q);
      default:  csr_rvalue = '0;
    endcase
    for (int i = 0; i < SAVE_NUM; i++) begin
      if (csr_num == save_addr(i)) csr_rvalue = save_q[i];
    end
  end

  always_comb begin
    crmd_d     = crmd_q;
    prmd_d     = prmd_q;
    lie_d      = lie_q;
    is_d       = is_q;
    ecode_d    = ecode_q;
    esub_d     = esub_q;
    era_d      = era_q;
    badv_d     = badv_q;
    eentry_d   = eentry_q;
    tid_d      = tid_q;
    tcfg_d     = tcfg_q;
    tval_d     = tval_q;
    timer_fire = 1'b0;
    for (int i = 0; i < SAVE_NUM; i++) save_d[i] = save_q[i];

    if (wr) begin
      case (csr_num)
        A_CRMD:   crmd_d = (crmd_q & keep[3:0]) | wsel[3:0];
        A_PRMD:   prmd_d = (prmd_q & keep[2:0]) | wsel[2:0];
        A_ECFG:   lie_d = ((lie_q & keep[12:0]) | wsel[12:0]) & LIE_MASK;
        A_ESTAT:  is_d[1:0] = (is_q[1:0] & keep[1:0]) | wsel[1:0];
        A_ERA:    era_d = (era_q & keep) | wsel;
        A_BADV:   badv_d = (badv_q & keep) | wsel;
        A_EENTRY: eentry_d = (eentry_q & keep[31:6]) | wsel[31:6];
        A_TID:    tid_d = (tid_q & keep) | wsel;
        A_TCFG:   tcfg_d = (tcfg_q & keep[TIMER_W-1:0]) | wsel[TIMER_W-1:0];
        default:  ;
      endcase
      for (int i = 0; i < SAVE_NUM; i++) begin
        if (csr_num == save_addr(i)) save_d[i] = (save_q[i] & keep) | wsel;
      end
    end

    // Counting uses the committed config; a fresh enable loads instead.
    if (tcfg_wr && tcfg_d[0]) begin
      tval_d = {tcfg_d[TIMER_W-1:2], 2'b00};
    end else if (tcfg_q[0]) begin
      if (tval_q != '0) begin
        tval_d     = tval_q - TIMER_W'(1);
        timer_fire = (tval_q == TIMER_W'(1));
      end else if (tcfg_q[1]) begin
        tval_d = {tcfg_q[TIMER_W-1:2], 2'b00};
      end
    end

    is_d[9:2] = hw_int_in;
    is_d[10]  = 1'b0;
    is_d[12]  = ipi_int_in;
    if (ticlr) is_d[11] = 1'b0;
    if (timer_fire) is_d[11] = 1'b1;

    if (ertn_flush) crmd_d[2:0] = prmd_q;

    if (wb_ex) begin
      prmd_d      = crmd_q[2:0];
      crmd_d[2:0] = 3'b000;
      era_d       = wb_pc;
      ecode_d     = wb_ecode;
      esub_d      = wb_esubcode;
      if (wb_ecode == EC_ADEF) badv_d = wb_pc;
      if (wb_ecode == EC_ALE) badv_d = wb_vaddr;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      crmd_q   <= 4'h8;
      prmd_q   <= '0;
      lie_q    <= '0;
      is_q     <= '0;
      ecode_q  <= '0;
      esub_q   <= '0;
      era_q    <= '0;
      badv_q   <= '0;
      eentry_q <= '0;
      tid_q    <= coreid_in;
      tcfg_q   <= '0;
      tval_q   <= '0;
      for (int i = 0; i < SAVE_NUM; i++) save_q[i] <= '0;
    end else begin
      crmd_q   <= crmd_d;
      prmd_q   <= prmd_d;
      lie_q    <= lie_d;
      is_q     <= is_d;
      ecode_q  <= ecode_d;
      esub_q   <= esub_d;
      era_q    <= era_d;
      badv_q   <= badv_d;
      eentry_q <= eentry_d;
      tid_q    <= tid_d;
      tcfg_q   <= tcfg_d;
      tval_q   <= tval_d;
      for (int i = 0; i < SAVE_NUM; i++) save_q[i] <= save_d[i];
    end
  end

  assign has_int  = crmd_q[2] & |(is_q & lie_q);
  assign ex_entry = {eentry_q, 6'd0};
  assign ertn_pc  = era_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        resetn;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] coreid_in;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] ertn_pc;

  int passed = 0;
  int total  = 0;

  csr_file dut (
    .clk(clk), .resetn(resetn), .csr_re(csr_re), .csr_num(csr_num),
    .csr_rvalue(csr_rvalue), .csr_we(csr_we), .csr_wmask(csr_wmask),
    .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
    .ertn_flush(ertn_flush), .hw_int_in(hw_int_in),
    .ipi_int_in(ipi_int_in), .coreid_in(coreid_in), .has_int(has_int),
    .ex_entry(ex_entry), .ertn_pc(ertn_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [13:0] n, output logic [31:0] v);
    csr_num = n;
    #1;
    v = csr_rvalue;
  endtask

  task automatic csr_wr(input logic [13:0] n, input logic [31:0] m,
                        input logic [31:0] v);
    csr_we = 1'b1; csr_num = n; csr_wmask = m; csr_wvalue = v;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [13:0] za [14] = '{14'h1, 14'h4, 14'h5, 14'h6, 14'h7, 14'hC,
      14'h30, 14'h31, 14'h32, 14'h33, 14'h41, 14'h42, 14'h44, 14'h100};
    coreid_in = 32'h5;
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    rd(14'h0, v);
    total++; if (v !== 32'h8) $display("FAIL crmd_reset got=%h exp=%h", v, 32'h8); else passed++;
    rd(14'h40, v);
    total++; if (v !== 32'h5) $display("FAIL tid_reset got=%h exp=%h", v, 32'h5); else passed++;
    for (int i = 0; i < 14; i++) begin
      rd(za[i], v);
      total++; if (v !== 32'h0) $display("FAIL zero_reset addr=%h got=%h exp=0", za[i], v); else passed++;
    end
    total++; if (has_int !== 1'b0) $display("FAIL has_int_reset got=%b exp=0", has_int); else passed++;
    total++; if (ex_entry !== 32'h0) $display("FAIL ex_entry_reset got=%h exp=0", ex_entry); else passed++;
    total++; if (ertn_pc !== 32'h0) $display("FAIL ertn_pc_reset got=%h exp=0", ertn_pc); else passed++;
  endtask

  task automatic test_masked_write();
    logic [31:0] v;
    csr_wr(14'h30, 32'h0000FF00, 32'hFFFFFFFF);
    rd(14'h30, v);
    total++; if (v !== 32'h0000FF00) $display("FAIL save0_mask got=%h exp=%h", v, 32'h0000FF00); else passed++;
    csr_wr(14'h30, 32'h0, 32'h0);
    rd(14'h30, v);
    total++; if (v !== 32'h0000FF00) $display("FAIL save0_nomask got=%h exp=%h", v, 32'h0000FF00); else passed++;
    csr_wr(14'h30, 32'h0F0F0F0F, 32'h12345678);
    rd(14'h30, v);
    total++; if (v !== 32'h0204F608) $display("FAIL save0_mix got=%h exp=%h", v, 32'h0204F608); else passed++;
    csr_wr(14'h4, 32'hFFFFFFFF, 32'hFFFFFFFF);
    rd(14'h4, v);
    total++; if (v !== 32'h00001BFF) $display("FAIL ecfg_lie got=%h exp=%h", v, 32'h1BFF); else passed++;
    csr_wr(14'h4, 32'hFFFFFFFF, 32'h0);
    csr_wr(14'hC, 32'hFFFFFFFF, 32'hFFFFFFFF);
    rd(14'hC, v);
    total++; if (v !== 32'hFFFFFFC0) $display("FAIL eentry got=%h exp=%h", v, 32'hFFFFFFC0); else passed++;
    total++; if (ex_entry !== 32'hFFFFFFC0) $display("FAIL ex_entry got=%h exp=%h", ex_entry, 32'hFFFFFFC0); else passed++;
    csr_wr(14'h42, 32'hFFFFFFFF, 32'hFFFFFFFF);
    rd(14'h42, v);
    total++; if (v !== 32'h0) $display("FAIL tval_ro got=%h exp=0", v); else passed++;
    csr_wr(14'h100, 32'hFFFFFFFF, 32'hFFFFFFFF);
    rd(14'h100, v);
    total++; if (v !== 32'h0) $display("FAIL unmapped got=%h exp=0", v); else passed++;
  endtask

  task automatic test_exception();
    logic [31:0] v;
    csr_wr(14'h0, 32'h7, 32'h7);
    rd(14'h0, v);
    total++; if (v !== 32'hF) $display("FAIL crmd_set got=%h exp=%h", v, 32'hF); else passed++;
    wb_ex = 1'b1; wb_ecode = 6'h09; wb_esubcode = 9'h0;
    wb_pc = 32'h1C000100; wb_vaddr = 32'h1234;
    tick();
    wb_ex = 1'b0;
    rd(14'h6, v);
    total++; if (v !== 32'h1C000100) $display("FAIL era_ale got=%h exp=%h", v, 32'h1C000100); else passed++;
    total++; if (ertn_pc !== 32'h1C000100) $display("FAIL ertn_pc got=%h exp=%h", ertn_pc, 32'h1C000100); else passed++;
    rd(14'h7, v);
    total++; if (v !== 32'h1234) $display("FAIL badv_ale got=%h exp=%h", v, 32'h1234); else passed++;
    rd(14'h5, v);
    total++; if (v[21:16] !== 6'h09) $display("FAIL estat_ecode got=%h exp=09", v[21:16]); else passed++;
    rd(14'h1, v);
    total++; if (v !== 32'h7) $display("FAIL prmd_ex got=%h exp=7", v); else passed++;
    rd(14'h0, v);
    total++; if (v !== 32'h8) $display("FAIL crmd_ex got=%h exp=8", v); else passed++;
    ertn_flush = 1'b1;
    tick();
    ertn_flush = 1'b0;
    rd(14'h0, v);
    total++; if (v !== 32'hF) $display("FAIL crmd_ertn got=%h exp=%h", v, 32'hF); else passed++;
    wb_ex = 1'b1; wb_ecode = 6'h08; wb_esubcode = 9'h1; wb_pc = 32'h1C000200;
    tick();
    wb_ex = 1'b0;
    rd(14'h7, v);
    total++; if (v !== 32'h1C000200) $display("FAIL badv_adef got=%h exp=%h", v, 32'h1C000200); else passed++;
    rd(14'h5, v);
    total++; if (v !== 32'h00480000) $display("FAIL estat_adef got=%h exp=%h", v, 32'h00480000); else passed++;
    wb_ex = 1'b1; ertn_flush = 1'b1; wb_ecode = 6'h0B; wb_esubcode = 9'h0;
    wb_pc = 32'h1C000300;
    tick();
    wb_ex = 1'b0; ertn_flush = 1'b0;
    rd(14'h0, v);
    total++; if (v !== 32'h8) $display("FAIL crmd_ex_ertn got=%h exp=8", v); else passed++;
    rd(14'h1, v);
    total++; if (v !== 32'h0) $display("FAIL prmd_ex_ertn got=%h exp=0", v); else passed++;
    rd(14'h7, v);
    total++; if (v !== 32'h1C000200) $display("FAIL badv_keep got=%h exp=%h", v, 32'h1C000200); else passed++;
  endtask

  task automatic test_ex_vs_write();
    logic [31:0] v;
    csr_we = 1'b1; csr_num = 14'h31; csr_wmask = 32'hFFFFFFFF;
    csr_wvalue = 32'hDEADBEEF;
    wb_ex = 1'b1; wb_ecode = 6'h0B; wb_pc = 32'h1C000400;
    tick();
    csr_we = 1'b0; wb_ex = 1'b0;
    rd(14'h31, v);
    total++; if (v !== 32'h0) $display("FAIL save1_discard got=%h exp=0", v); else passed++;
    rd(14'h6, v);
    total++; if (v !== 32'h1C000400) $display("FAIL era_collide got=%h exp=%h", v, 32'h1C000400); else passed++;
  endtask

  task automatic test_timer();
    logic [31:0] v;
    csr_wr(14'h4, 32'hFFFFFFFF, 32'h800);
    csr_wr(14'h0, 32'h4, 32'h4);
    csr_wr(14'h41, 32'hFFFFFFFF, 32'hB);
    rd(14'h42, v);
    total++; if (v !== 32'h8) $display("FAIL tval_load got=%h exp=8", v); else passed++;
    for (int i = 7; i >= 1; i--) begin
      tick();
      rd(14'h42, v);
      total++; if (v !== 32'(i)) $display("FAIL tval_count got=%h exp=%h", v, 32'(i)); else passed++;
      total++; if (has_int !== 1'b0) $display("FAIL has_int_early got=%b exp=0", has_int); else passed++;
    end
    tick();
    rd(14'h42, v);
    total++; if (v !== 32'h0) $display("FAIL tval_zero got=%h exp=0", v); else passed++;
    rd(14'h5, v);
    total++; if (v[11] !== 1'b1) $display("FAIL is11_set got=%b exp=1", v[11]); else passed++;
    total++; if (has_int !== 1'b1) $display("FAIL has_int_timer got=%b exp=1", has_int); else passed++;
    tick();
    rd(14'h42, v);
    total++; if (v !== 32'h8) $display("FAIL tval_reload got=%h exp=8", v); else passed++;
    csr_wr(14'h44, 32'h1, 32'h1);
    rd(14'h5, v);
    total++; if (v[11] !== 1'b0) $display("FAIL is11_clr got=%b exp=0", v[11]); else passed++;
    total++; if (has_int !== 1'b0) $display("FAIL has_int_clr got=%b exp=0", has_int); else passed++;
    csr_wr(14'h41, 32'hFFFFFFFF, 32'h0);
    tick(); tick();
    rd(14'h42, v);
    total++; if (v !== 32'h6) $display("FAIL tval_freeze got=%h exp=6", v); else passed++;
    csr_wr(14'h41, 32'hFFFFFFFF, 32'h5);
    tick(); tick(); tick();
    rd(14'h42, v);
    total++; if (v !== 32'h1) $display("FAIL tval_one got=%h exp=1", v); else passed++;
    csr_wr(14'h44, 32'h1, 32'h1);
    rd(14'h5, v);
    total++; if (v[11] !== 1'b1) $display("FAIL set_wins got=%b exp=1", v[11]); else passed++;
    csr_wr(14'h44, 32'h1, 32'h1);
    tick(); tick(); tick();
    rd(14'h42, v);
    total++; if (v !== 32'h0) $display("FAIL oneshot_hold got=%h exp=0", v); else passed++;
    rd(14'h5, v);
    total++; if (v[11] !== 1'b0) $display("FAIL oneshot_noset got=%b exp=0", v[11]); else passed++;
  endtask

  task automatic test_hw_int();
    logic [31:0] v;
    csr_wr(14'h4, 32'hFFFFFFFF, 32'h4);
    hw_int_in = 8'h01;
    rd(14'h5, v);
    total++; if (v[2] !== 1'b0) $display("FAIL is2_early got=%b exp=0", v[2]); else passed++;
    tick();
    rd(14'h5, v);
    total++; if (v[2] !== 1'b1) $display("FAIL is2_set got=%b exp=1", v[2]); else passed++;
    total++; if (has_int !== 1'b1) $display("FAIL has_int_hw got=%b exp=1", has_int); else passed++;
    csr_wr(14'h0, 32'h4, 32'h0);
    total++; if (has_int !== 1'b0) $display("FAIL has_int_ie0 got=%b exp=0", has_int); else passed++;
    hw_int_in = 8'h00; ipi_int_in = 1'b1;
    csr_wr(14'h4, 32'hFFFFFFFF, 32'h1000);
    csr_wr(14'h0, 32'h4, 32'h4);
    rd(14'h5, v);
    total++; if (v[12] !== 1'b1) $display("FAIL is12_ipi got=%b exp=1", v[12]); else passed++;
    total++; if (has_int !== 1'b1) $display("FAIL has_int_ipi got=%b exp=1", has_int); else passed++;
  endtask

  initial begin
    resetn = 1'b0; csr_re = 1'b1; csr_num = '0; csr_we = 1'b0;
    csr_wmask = '0; csr_wvalue = '0; wb_ex = 1'b0; wb_ecode = '0;
    wb_esubcode = '0; wb_pc = '0; wb_vaddr = '0; ertn_flush = 1'b0;
    hw_int_in = '0; ipi_int_in = 1'b0; coreid_in = '0;
    #1;
    test_reset();
    test_masked_write();
    test_exception();
    test_ex_vs_write();
    test_timer();
    test_hw_int();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
